hazard_scoreboard: RTL

//  Parametrised hazard/forwarding unit for the fewcore in-order pipeline. Sits beside decode.

---
 rtl/hazard_scoreboard_pkg.sv | 24 ++
 rtl/hazard_scoreboard_if.sv | 35 +++
 rtl/hazard_scoreboard_src_match.sv | 50 +++++
 rtl/hazard_scoreboard.sv | 107 ++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the fewcore hazard scoreboard.
package fewcore_pkg;

    // Widest register address an entry can hold; narrower addresses are zero-extended.
    localparam int SB_RD_W  = 8;
    // Stage index width; covers stage numbers 0..6 and forward codes 0..7.
    localparam int SB_STG_W = 3;

    // Forward select code meaning "read the register file".
    localparam logic [SB_STG_W-1:0] FWD_REGFILE = 3'd0;

    // One in-flight register write tracked by the scoreboard.
    typedef struct packed {
        logic                valid;
        logic [SB_RD_W-1:0]  rd;
        logic [SB_STG_W-1:0] rdy_stage;
    } sb_entry_t;

    // Forward select code for the output of stage k.
    function automatic logic [SB_STG_W-1:0] fwd_stage(input logic [SB_STG_W-1:0] k);
        return k + 3'd1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode <-> scoreboard interface: issue request in, stall/forward decisions out.
interface hazard_scoreboard_if #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int DEPTH = 3
);
    localparam int SEL_W = $clog2(DEPTH + 1);

    logic             issue_valid;
    logic [RA_W-1:0]  issue_rs1;
    logic [RA_W-1:0]  issue_rs2;
    logic             issue_use1;
    logic             issue_use2;
    logic [RA_W-1:0]  issue_rd;
    logic             issue_we;
    logic             issue_load;
    logic             flush;
    logic             stall;
    logic [SEL_W-1:0] fwd_sel1;
    logic [SEL_W-1:0] fwd_sel2;
    logic [XLEN-1:0]  stall_count;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_use1, issue_use2,
               issue_rd, issue_we, issue_load, flush,
        input  stall, fwd_sel1, fwd_sel2, stall_count
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_use1, issue_use2,
               issue_rd, issue_we, issue_load, flush,
        output stall, fwd_sel1, fwd_sel2, stall_count
    );

endinterface

// File: rtl/hazard_scoreboard_src_match.sv
// Priority scan of the in-flight entries for one source operand.
module sb_src_match
    import fewcore_pkg::*;
#(
    parameter int RA_W  = 5,
    parameter int DEPTH = 3,
    parameter int SEL_W = 2
) (
    input  sb_entry_t [DEPTH-1:0] entries,
    input  logic [RA_W-1:0]       src,
    input  logic                  use_src,
    output logic                  hit,
    output logic                  hazard,
    output logic [SEL_W-1:0]      sel
);

    logic                hit_s;
    logic                hazard_s;
    logic [SEL_W-1:0]    sel_s;
    logic [SB_STG_W-1:0] code_s;

    // Scan oldest to youngest so the youngest (lowest stage) match is the last writer.
    always_comb begin
        hit_s    = 1'b0;
        hazard_s = 1'b0;
        sel_s    = SEL_W'(FWD_REGFILE);
        code_s   = FWD_REGFILE;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (entries[k].valid && (entries[k].rd == SB_RD_W'(src)) && use_src &&
                (src != {RA_W{1'b0}})) begin
                hit_s = 1'b1;
                if (SB_STG_W'(k) >= entries[k].rdy_stage) begin
                    hazard_s = 1'b0;
                    code_s   = fwd_stage(SB_STG_W'(k));
                    sel_s    = code_s[SEL_W-1:0];
                end else begin
                    hazard_s = 1'b1;
                    sel_s    = SEL_W'(FWD_REGFILE);
                end
            end else begin
                hit_s = hit_s;
            end
        end
    end

    assign hit    = hit_s;
    assign hazard = hazard_s;
    assign sel    = sel_s;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit: tracks in-flight writes, picks forward sources, stalls load-use.
module hazard_scoreboard
    import fewcore_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RA_W     = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1
) (
    input logic                clk,
    input logic                reset,
    hazard_scoreboard_if.slave sb
);

    localparam int SEL_W = $clog2(DEPTH + 1);
    localparam logic [SEL_W-1:0] SEL_RF = SEL_W'(FWD_REGFILE);

    if ((LOAD_LAT < 1) || (LOAD_LAT > DEPTH - 1) || (DEPTH < 2) || (DEPTH > 7) ||
        (RA_W > SB_RD_W)) begin : g_bad_cfg
        $error("hazard_scoreboard: illegal DEPTH/LOAD_LAT/RA_W combination");
    end

    sb_entry_t [DEPTH-1:0] entries_r;
    sb_entry_t             new_entry_s;
    logic [XLEN-1:0]       stall_cnt_r;

    logic             hit1_s, haz1_s, hit2_s, haz2_s;
    logic [SEL_W-1:0] raw_sel1_s, raw_sel2_s;
    logic             stall_s;
    logic [SEL_W-1:0] sel1_s, sel2_s;

    sb_src_match #(.RA_W(RA_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match1 (
        .entries (entries_r),
        .src     (sb.issue_rs1),
        .use_src (sb.issue_use1),
        .hit     (hit1_s),
        .hazard  (haz1_s),
        .sel     (raw_sel1_s)
    );

    sb_src_match #(.RA_W(RA_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match2 (
        .entries (entries_r),
        .src     (sb.issue_rs2),
        .use_src (sb.issue_use2),
        .hit     (hit2_s),
        .hazard  (haz2_s),
        .sel     (raw_sel2_s)
    );

    // Stall and forward decisions; reset forces the register-file path with no stall.
    always_comb begin
        stall_s = 1'b0;
        sel1_s  = SEL_RF;
        sel2_s  = SEL_RF;
        if (reset) begin
            stall_s = 1'b0;
            sel1_s  = SEL_RF;
            sel2_s  = SEL_RF;
        end else begin
            stall_s = sb.issue_valid & ~sb.flush & (haz1_s | haz2_s);
            sel1_s  = (hit1_s && !haz1_s) ? raw_sel1_s : SEL_RF;
            sel2_s  = (hit2_s && !haz2_s) ? raw_sel2_s : SEL_RF;
        end
    end

    // Entry entering stage 0: the issuing write, or a bubble on stall/flush/x0/no-write.
    always_comb begin
        new_entry_s = '0;
        if (sb.issue_valid && sb.issue_we && (sb.issue_rd != {RA_W{1'b0}}) &&
            !stall_s && !sb.flush) begin
            new_entry_s.valid     = 1'b1;
            new_entry_s.rd        = SB_RD_W'(sb.issue_rd);
            new_entry_s.rdy_stage = sb.issue_load ? SB_STG_W'(LOAD_LAT) : SB_STG_W'(0);
        end else begin
            new_entry_s = '0;
        end
    end

    // Pipeline shadow: every entry advances one stage per cycle; the last stage retires.
    always_ff @(posedge clk) begin
        if (reset) begin
            entries_r <= '0;
        end else begin
            entries_r[0] <= new_entry_s;
            for (int k = 1; k < DEPTH; k++) begin
                entries_r[k] <= entries_r[k-1];
            end
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= {XLEN{1'b0}};
        end else if (stall_s && (stall_cnt_r != {XLEN{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + XLEN'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign sb.stall       = stall_s;
    assign sb.fwd_sel1    = sel1_s;
    assign sb.fwd_sel2    = sel2_s;
    assign sb.stall_count = stall_cnt_r;

endmodule
